// File: rtl/iir_filter_ctrl.sv
// iir_filter_ctrl
// Sequencer and configuration front-end for the runtime-coefficient build of
// the 3-tap stereo IIR filter. It generates the filter clock enables, keeps a
// byte-addressed shadow bank of coefficients written over the register bus, and
// commits the whole bank to the active outputs in one clock on a sample
// boundary, optionally flushing the filter state at the same time.
//
// Optional feature: define IIR_FILTER_CTRL_READBACK_EN to read shadow bytes
// back on rdata (addr 0-16) and the active cx bytes on addr 19-23. Without it,
// rdata returns only the status register (addr 18) and 0 elsewhere.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   run        in   1: strobe generation enabled; 0: divider/phase held at 0
//   wr_en      in   one-clk register write strobe (no back-pressure: every
//                   strobe is accepted on the clk edge that samples it)
//   addr       in   [4:0] register address (write and read)
//   wdata      in   [7:0] write data
//   rdata      out  [7:0] read data for addr (combinational)
//   ce         out  filter clock enable, one clk every CE_DIV clks
//   sample_ce  out  filter output-sample strobe
//   cx         out  [39:0] active X gain
//   cx0..cx2   out  [7:0]  active X tap scales
//   cy0..cy2   out  [23:0] active Y coefficients
//   flt_reset  out  filter state flush pulse (high during the transfer clk)
//   pending    out  commit requested, not yet applied
//   fsm_state  out  [1:0] commit FSM state for debug: 0 IDLE, 1 ARMED, 2 XFER
module iir_filter_ctrl #(
    parameter int CE_DIV = 562,
    parameter int STEREO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        wr_en,
    input  logic [4:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ce,
    output logic        sample_ce,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic        flt_reset,
    output logic        pending,
    output logic [1:0]  fsm_state
);

    localparam int           DW       = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CE_DIV - 1);
    localparam int           NREG     = 17;
    localparam logic [4:0]   A_NREG   = 5'd17;
    localparam logic [4:0]   A_CTRL   = 5'd17;
    localparam logic [4:0]   A_STAT   = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_XFER  = 2'd2
    } state_e;

    // ---------------- clock-enable divider ----------------
    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;

    assign ce        = run && (div_q == DIV_MAX);
    // In stereo the filter needs two ce per output sample (left, right);
    // phase marks the second one.
    assign sample_ce = (STEREO != 0) ? (ce && phase_q) : ce;

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (!run) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
            if (ce) phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    // ---------------- shadow bank ----------------
    logic [7:0] shadow_q [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
        end else if (wr_en && (addr < A_NREG)) begin
            shadow_q[addr] <= wdata;
        end
    end

    // ---------------- commit FSM ----------------
    state_e state_q, state_d;
    logic   pending_q, pending_d;
    logic   flush_q, flush_d;
    logic   load;
    logic   commit_wr;

    assign commit_wr = wr_en && (addr == A_CTRL) && wdata[0];

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        flush_d   = flush_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A commit that coincides with sample_ce only arms; the
                // transfer waits for the next sample boundary.
                if (commit_wr) begin
                    state_d   = S_ARMED;
                    pending_d = 1'b1;
                    flush_d   = wdata[1];
                end
            end
            S_ARMED: begin
                if (commit_wr) flush_d = flush_q | wdata[1];
                // With run low there are no sample boundaries to wait for.
                if (sample_ce || !run) state_d = S_XFER;
            end
            S_XFER: begin
                load = 1'b1;
                if (commit_wr) begin
                    state_d   = S_ARMED;
                    pending_d = 1'b1;
                    flush_d   = wdata[1];
                end else begin
                    state_d   = S_IDLE;
                    pending_d = 1'b0;
                    flush_d   = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
                flush_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            flush_q   <= flush_d;
        end
    end

    assign pending   = pending_q;
    assign flt_reset = (state_q == S_XFER) && flush_q;
    assign fsm_state = state_q;

    // ---------------- active coefficient set ----------------
    // Loaded from shadow_q as it stood before this clk's edge, so a bus write
    // landing in the transfer clk stays in shadow for the next commit.
    logic [39:0] cx_q;
    logic [7:0]  cx0_q, cx1_q, cx2_q;
    logic [23:0] cy0_q, cy1_q, cy2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx_q  <= '0;
            cx0_q <= '0;
            cx1_q <= '0;
            cx2_q <= '0;
            cy0_q <= '0;
            cy1_q <= '0;
            cy2_q <= '0;
        end else if (load) begin
            cx_q  <= {shadow_q[4], shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
            cx0_q <= shadow_q[5];
            cx1_q <= shadow_q[6];
            cx2_q <= shadow_q[7];
            cy0_q <= {shadow_q[10], shadow_q[9], shadow_q[8]};
            cy1_q <= {shadow_q[13], shadow_q[12], shadow_q[11]};
            cy2_q <= {shadow_q[16], shadow_q[15], shadow_q[14]};
        end
    end

    assign cx  = cx_q;
    assign cx0 = cx0_q;
    assign cx1 = cx1_q;
    assign cx2 = cx2_q;
    assign cy0 = cy0_q;
    assign cy1 = cy1_q;
    assign cy2 = cy2_q;

    // ---------------- read mux ----------------
    always_comb begin
        rdata = 8'h00;
`ifdef IIR_FILTER_CTRL_READBACK_EN
        if (addr < A_NREG) begin
            rdata = shadow_q[addr];
        end else begin
            case (addr)
                A_STAT: rdata = {7'b0, pending_q};
                5'd19:  rdata = cx_q[7:0];
                5'd20:  rdata = cx_q[15:8];
                5'd21:  rdata = cx_q[23:16];
                5'd22:  rdata = cx_q[31:24];
                5'd23:  rdata = cx_q[39:32];
                default: rdata = 8'h00;
            endcase
        end
`else
        if (addr == A_STAT) rdata = {7'b0, pending_q};
`endif
    end

endmodule

// File: tb/tb_iir_filter_ctrl.sv
module tb_iir_filter_ctrl;

    localparam int CE_DIV = 4;
    localparam int W      = 148;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset, run, wr_en;
    logic [4:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ce, sample_ce, flt_reset, pending;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    iir_filter_ctrl #(.CE_DIV(CE_DIV), .STEREO(1)) dut (
        .clk(clk), .reset(reset), .run(run), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ce(ce), .sample_ce(sample_ce),
        .cx(cx), .cx0(cx0), .cx1(cx1), .cx2(cx2),
        .cy0(cy0), .cy1(cy1), .cy2(cy2),
        .flt_reset(flt_reset), .pending(pending), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // run_cnt counts clks spent with run=1 since run was last low (or reset);
    // ce and sample_ce follow from it arithmetically.
    int         run_cnt;
    logic       m_pend, m_flush, m_xfer;
    logic [7:0] m_shadow [17];
    logic [7:0] m_active [17];

    function automatic logic m_ce();
        return run && ((run_cnt % CE_DIV) == CE_DIV - 1);
    endfunction

    function automatic logic m_smp();
        return m_ce() && (((run_cnt / CE_DIV) % 2) == 1);
    endfunction

    function automatic logic [7:0] m_rdata();
        logic [7:0] r;
        int idx;
        r = 8'h00;
        idx = int'(addr);
`ifdef IIR_FILTER_CTRL_READBACK_EN
        if (idx <= 16) r = m_shadow[idx];
        else if (idx == 18) r = {7'b0, m_pend};
        else if (idx >= 19 && idx <= 23) r = m_active[idx - 19];
`else
        if (idx == 18) r = {7'b0, m_pend};
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] model_expect();
        return {m_ce(), m_smp(), m_pend, m_xfer & m_flush, m_rdata(),
                m_active[4], m_active[3], m_active[2], m_active[1], m_active[0],
                m_active[5], m_active[6], m_active[7],
                m_active[10], m_active[9], m_active[8],
                m_active[13], m_active[12], m_active[11],
                m_active[16], m_active[15], m_active[14]};
    endfunction

    task automatic model_reset();
        run_cnt = 0;
        m_pend  = 1'b0;
        m_flush = 1'b0;
        m_xfer  = 1'b0;
        for (int i = 0; i < 17; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
    endtask

    // Applies one clk edge worth of behaviour using the inputs of that clk.
    task automatic model_advance();
        logic commit, nx;
        commit = wr_en && (addr == 5'd17) && wdata[0];
        nx = m_pend && !m_xfer && (m_smp() || !run);
        if (m_xfer) begin
            for (int i = 0; i < 17; i++) m_active[i] = m_shadow[i];
            m_pend  = 1'b0;
            m_flush = 1'b0;
        end
        if (commit) begin
            m_flush = m_flush | wdata[1];
            m_pend  = 1'b1;
        end
        m_xfer = nx;
        if (wr_en && (int'(addr) <= 16)) m_shadow[int'(addr)] = wdata;
        run_cnt = run ? run_cnt + 1 : 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
        run   = r;
        wr_en = w;
        addr  = a;
        wdata = d;
    endtask

    // Sample outputs mid-cycle and compare against the model.
    task automatic settle();
        logic [W-1:0] got, e;
        @(negedge clk);
        if (reset) model_reset();
        exp_q.push_back(model_expect());
        got = {ce, sample_ce, pending, flt_reset, rdata, cx, cx0, cx1, cx2, cy0, cy1, cy2};
        e = exp_q.pop_front();
        chk("model_outputs", got, e);
        chk("fsm_busy", fsm_state != 2'd0, m_pend);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_advance();
        #1;
    endtask

    task automatic do_reset(input logic r);
        reset = 1'b1;
        drive(r, 1'b0, 5'd18, 8'h00);
        repeat (2) begin
            settle();
            tick();
        end
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        run;
        logic        wr;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic        ce;
        logic        smp;
        logic        pend;
        logic [23:0] cy0;
        logic [7:0]  rd;
    } vec_t;

    vec_t tbl [18];

    initial begin
        model_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 8'h00);

        // cycle 1 is the first clk after reset release with run=1
        tbl[0]  = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b1, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 5'd8,  8'h00, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 5'd9,  8'h00, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, 5'd10, 8'h20, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b1, 1'b1, 1'b0, 24'h0, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 5'd17, 8'h01, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b1, 24'h0, 8'h01};
        tbl[11] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b1, 1'b0, 1'b1, 24'h0, 8'h01};
        tbl[12] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b1, 24'h0, 8'h01};
        tbl[13] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b1, 24'h0, 8'h01};
        tbl[14] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b1, 24'h0, 8'h01};
        tbl[15] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b1, 1'b1, 1'b1, 24'h0, 8'h01};
        tbl[16] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b1, 24'h0, 8'h01};
        tbl[17] = '{1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b0, 1'b0, 24'h200000, 8'h00};

        // reset state
        repeat (2) begin
            settle();
            chk("reset_pending", pending, 1'b0);
            chk("reset_cx", cx, 40'h0);
            tick();
        end
        reset = 1'b0;

        // ---- table: divider cadence and a plain commit ----
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].run, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            settle();
            chk($sformatf("tbl%0d_ce", i + 1), ce, tbl[i].ce);
            chk($sformatf("tbl%0d_sample_ce", i + 1), sample_ce, tbl[i].smp);
            chk($sformatf("tbl%0d_pending", i + 1), pending, tbl[i].pend);
            chk($sformatf("tbl%0d_cy0", i + 1), cy0, tbl[i].cy0);
            chk($sformatf("tbl%0d_rdata", i + 1), rdata, tbl[i].rd);
            chk($sformatf("tbl%0d_flt_reset", i + 1), flt_reset, 1'b0);
            tick();
        end

        // ---- commit+flush written in a sample_ce clk ----
        do_reset(1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) drive(1'b1, 1'b1, 5'd6, 8'h5A);
            else if (c == 8) drive(1'b1, 1'b1, 5'd17, 8'h03);
            else drive(1'b1, 1'b0, 5'd18, 8'h00);
            settle();
            if (c == 8) chk("flush_commit_on_sample", sample_ce, 1'b1);
            chk($sformatf("flush_c%0d_flt_reset", c), flt_reset, c == 17);
            if (c >= 9) chk($sformatf("flush_c%0d_pending", c), pending, c <= 17);
            chk($sformatf("flush_c%0d_cx1", c), cx1, (c >= 18) ? 8'h5A : 8'h00);
            tick();
        end

        // ---- run=0: commit transfers without waiting ----
        do_reset(1'b0);
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) drive(1'b0, 1'b1, 5'd5, 8'h83);
            else if (c == 2) drive(1'b0, 1'b1, 5'd17, 8'h01);
            else drive(1'b0, 1'b0, 5'd18, 8'h00);
            settle();
            chk($sformatf("norun_c%0d_ce", c), ce, 1'b0);
            chk($sformatf("norun_c%0d_pending", c), pending, (c == 3) || (c == 4));
            chk($sformatf("norun_c%0d_cx0", c), cx0, (c >= 5) ? 8'h83 : 8'h00);
            tick();
        end

        // ---- reset while ARMED ----
        do_reset(1'b1);
        drive(1'b1, 1'b1, 5'd14, 8'h77);
        settle(); tick();
        drive(1'b1, 1'b1, 5'd17, 8'h01);
        settle(); tick();
        drive(1'b1, 1'b0, 5'd18, 8'h00);
        settle();
        chk("armed_pending", pending, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        chk("async_reset_pending", pending, 1'b0);
        settle(); tick();
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            drive(1'b1, 1'b0, 5'd18, 8'h00);
            settle();
            chk($sformatf("post_rst_c%0d_cy2", c), cy2, 24'h0);
            chk($sformatf("post_rst_c%0d_status", c), rdata, 8'h00);
            tick();
        end

`ifdef IIR_FILTER_CTRL_READBACK_EN
        // ---- readback of shadow and active cx bytes ----
        do_reset(1'b0);
        drive(1'b0, 1'b1, 5'd0, 8'hAB);  settle(); tick();
        drive(1'b0, 1'b0, 5'd0, 8'h00);  settle();
        chk("rb_shadow0", rdata, 8'hAB); tick();
        drive(1'b0, 1'b0, 5'd19, 8'h00); settle();
        chk("rb_active0_before", rdata, 8'h00); tick();
        drive(1'b0, 1'b1, 5'd17, 8'h01); settle(); tick();
        drive(1'b0, 1'b0, 5'd19, 8'h00); settle();
        chk("rb_active0_armed", rdata, 8'h00); tick();
        settle();
        chk("rb_active0_xfer", rdata, 8'h00); tick();
        settle();
        chk("rb_active0_after", rdata, 8'hAB); tick();
`endif

        // ---- randomized traffic against the model ----
        do_reset(1'b1);
        for (int n = 0; n < 3000; n++) begin
            logic       r, w;
            logic [4:0] a;
            logic [7:0] d;
            r = ($urandom_range(0, 15) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 9) < 2) ? 5'd17 : 5'($urandom_range(0, 31));
            d = 8'($urandom_range(0, 255));
            reset = ($urandom_range(0, 299) == 0);
            drive(r, w, a, d);
            settle();
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_filter_ctrl.md
Name: iir_filter_ctrl

Overview:
Sequencer and configuration front-end for the runtime-coefficient (use_params=0) build of the 3-tap stereo IIR filter.
- Generates the filter's `ce` (2x sample rate in stereo) and `sample_ce` strobes from `clk`.
- Holds a byte-addressed shadow bank for cx/cx0..cx2/cy0..cy2, written by the audio register bus.
- Commits the bank atomically on a sample boundary, optionally flushing filter state, so the filter never runs on a half-updated coefficient set.

Parameters:
CE_DIV, 562, clk cycles per `ce` period (>=2)
STEREO, 1, 1: `sample_ce` on every 2nd `ce`; 0: `sample_ce` on every `ce`

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  1: strobe generation enabled; 0: counters held
wr_en  in  1  register write strobe, one clk
addr  in  5  register address
wdata  in  8  write data
rdata  out  8  read data for `addr`
ce  out  1  filter clock enable
sample_ce  out  1  filter output-sample strobe
cx  out  40  active X gain
cx0, cx1, cx2  out  8 each  active X tap scales
cy0, cy1, cy2  out  24 each  active Y coefficients
flt_reset  out  1  filter state flush pulse
pending  out  1  commit requested, not yet applied

Behaviour:
- Reset (async): divider=0, phase=0, all shadow and active registers=0, `ce`=`sample_ce`=`flt_reset`=`pending`=0, flush flag=0.
- Register map (little-endian bytes):
  - 0-4: cx[7:0]..cx[39:32]
  - 5/6/7: cx0/cx1/cx2
  - 8-10: cy0
  - 11-13: cy1
  - 14-16: cy2
  - 17: control, write-only; bit0=commit, bit1=flush
  - 18: status, read `{7'b0,pending}`
  - 19-31: write ignored, read 0
- Shadow writes take effect the clk after `wr_en`. Active outputs change only on transfer.
- Divider:
  - With `run`=1, it counts 0..CE_DIV-1 and wraps.
  - `ce`=1 for exactly one clk when divider==CE_DIV-1. First `ce` occurs CE_DIV clks after `run` rises from reset.
  - `phase` toggles on each `ce`.
  - `sample_ce`=`ce` & (`phase`==1), or `sample_ce`=`ce` when STEREO=0.
- `run`=0: divider and phase held at 0, `ce`=`sample_ce`=0.
- FSM states:
  - IDLE → ARMED on a control write with bit0=1. Sets `pending`; latches flush flag = bit1.
  - ARMED → XFER on the clk where `sample_ce`=1. If `run`=0, ARMED → XFER on the next clk.
  - XFER, one clk: active <= shadow (all fields together), `pending` cleared. `flt_reset`=1 during XFER iff flush flag set; flag then cleared. → IDLE.
- Commit write in the same clk as `sample_ce`: transfer waits for the next `sample_ce`, never the same clk.
- Commit while ARMED: stays ARMED; flush flag ORed with new bit1.
- Shadow write in the XFER clk: the transfer uses the pre-write value; the new byte stays in shadow, unapplied until the next commit.
- Reset mid-ARMED/XFER: returns to IDLE, commit discarded, active regs=0.

Optional Feature:
Macro IIR_FILTER_CTRL_READBACK_EN.
- Defined: `rdata` returns the shadow byte at `addr`; addresses 19-23 return the active bytes of cx.
- Undefined: `rdata` returns 0 except the status register (addr 18), and the active-readback logic is not built.

Test Plan:
- Reset released, `run`=1, CE_DIV=4, STEREO=1 -> `ce` at clks 4,8,12,16; `sample_ce` at 8,16; all coefficient outputs 0.
- Write addr 8..10 = 00,00,20, commit (ctrl=01) at clk 10 -> `pending`=1 until the clk after `sample_ce`@16; cy0 becomes 24'h200000 then, not before; `flt_reset` stays 0.
- Commit with ctrl=03 written in the same clk as `sample_ce` -> transfer and a single-clk `flt_reset` at the following `sample_ce`, not the current one.
- `run`=0, write cx0=0x83, commit -> cx0=0x83 and `pending`=0 within 2 clks; no `ce`.
- Assert `reset` while ARMED -> `pending`=0 immediately; later `sample_ce` changes nothing; status read=0x00.
- With IIR_FILTER_CTRL_READBACK_EN: write addr 0=0xAB, commit, read addr 0 -> 0xAB; read addr 19 -> 0x00 before transfer, 0xAB after.
